// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory responder: funct3 codes, FSM states,
// and lane helpers for byte-mask and alignment decoding.
package mem_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bytes of the 64-bit word touched by an access of this size at this offset.
    function automatic logic [7:0] byte_mask(input logic [2:0] funct3, input logic [2:0] offset);
        logic [7:0] base;
        case (funct3)
            F3_B, F3_BU: base = 8'h01;
            F3_H, F3_HU: base = 8'h03;
            F3_W, F3_WU: base = 8'h0F;
            default:     base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] offset);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W, F3_WU: mis = |offset[1:0];
            F3_D:        mis = |offset;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control unit (master) and the data memory responder (slave).
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [2:0]  funct3;
    logic [63:0] wdata;
    logic        ready;
    logic        ack;
    logic        err;
    logic [63:0] rdata;

    modport master (
        output req, we, addr, funct3, wdata,
        input  ready, ack, err, rdata
    );

    modport slave (
        input  req, we, addr, funct3, wdata,
        output ready, ack, err, rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic for a 64-bit word: load extract/extend and store byte merge.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] store_o
);
    logic [63:0] shifted;
    logic [63:0] wshift;
    logic [7:0]  mask;

    assign shifted = word_i >> {offset_i, 3'b000};
    assign wshift  = wdata_i << {offset_i, 3'b000};
    assign mask    = byte_mask(funct3_i, offset_i);

    always_comb begin
        load_o = shifted;
        case (funct3_i)
            F3_B:    load_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_o = {56'd0, shifted[7:0]};
            F3_HU:   load_o = {48'd0, shifted[15:0]};
            F3_WU:   load_o = {32'd0, shifted[31:0]};
            default: load_o = shifted;
        endcase
    end

    always_comb begin
        store_o = word_i;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                store_o[i*8 +: 8] = wshift[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: one request at a time, WAIT_STATES idle cycles, then a one-cycle ACK.
// Stores commit on the edge that ends the ACK cycle; reset during WAIT/RESP drops the transaction.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [63:0] addr_q;
    logic [2:0]  funct3_q;
    logic [63:0] wdata_q;
    logic        ready_q;
    logic        ack_q;
    logic        err_q;
    logic [63:0] rdata_q;
    logic [63:0] mem_q [DEPTH];

    // With zero wait states the response is registered on the accept edge, so the
    // datapath must look at the live request while idle and at the latches afterwards.
    logic        cur_we;
    logic [63:0] cur_addr;
    logic [2:0]  cur_funct3;
    logic [63:0] cur_wdata;

    always_comb begin
        cur_we     = we_q;
        cur_addr   = addr_q;
        cur_funct3 = funct3_q;
        cur_wdata  = wdata_q;
        if (state_q == IDLE) begin
            cur_we     = bus.we;
            cur_addr   = bus.addr;
            cur_funct3 = bus.funct3;
            cur_wdata  = bus.wdata;
        end
    end

    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             illegal;
    logic             err_d;
    logic [63:0]      load_data;
    logic [63:0]      store_word;
    logic [63:0]      rdata_d;

    assign idx          = cur_addr[IDX_W+2:3];
    assign out_of_range = |cur_addr[63:IDX_W+3];
    assign illegal      = (cur_funct3 == F3_ILL) || (cur_we && (cur_funct3 == F3_WU));
    assign err_d        = out_of_range || illegal || misaligned(cur_funct3, cur_addr[2:0]);
    assign rdata_d      = (err_d || cur_we) ? 64'd0 : load_data;

    mem_lane_align u_align (
        .word_i   (mem_q[idx]),
        .funct3_i (cur_funct3),
        .offset_i (cur_addr[2:0]),
        .wdata_i  (cur_wdata),
        .load_o   (load_data),
        .store_o  (store_word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 64'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 64'd0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        we_q     <= bus.we;
                        addr_q   <= bus.addr;
                        funct3_q <= bus.funct3;
                        wdata_q  <= bus.wdata;
                        cnt_q    <= 4'(WAIT_STATES);
                        ready_q  <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= err_d;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        err_q   <= err_d;
                        rdata_q <= rdata_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array has no reset; the commit edge is suppressed when reset wins.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == RESP) && we_q && !err_q) begin
            mem_q[idx] <= store_word;
        end
    end

    assign bus.ready = ready_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: DUT0 with 2 wait states, DUT1 with 0, checked against a byte-level model.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int WS0   = 2;
    localparam int WS1   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        req_s   [2];
    logic        we_s    [2];
    logic [63:0] addr_s  [2];
    logic [2:0]  f3_s    [2];
    logic [63:0] wd_s    [2];
    logic        ready_s [2];
    logic        ack_s   [2];
    logic        err_s   [2];
    logic [63:0] rdata_s [2];

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    assign if0.req = req_s[0];  assign if0.we = we_s[0];  assign if0.addr = addr_s[0];
    assign if0.funct3 = f3_s[0]; assign if0.wdata = wd_s[0];
    assign if1.req = req_s[1];  assign if1.we = we_s[1];  assign if1.addr = addr_s[1];
    assign if1.funct3 = f3_s[1]; assign if1.wdata = wd_s[1];
    assign ready_s[0] = if0.ready; assign ack_s[0] = if0.ack; assign err_s[0] = if0.err; assign rdata_s[0] = if0.rdata;
    assign ready_s[1] = if1.ready; assign ack_s[1] = if1.ack; assign err_s[1] = if1.err; assign rdata_s[1] = if1.rdata;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

    // Reference memory: a plain array of words per DUT, manipulated byte by byte.
    logic [63:0] mdl_mem [2][DEPTH];

    function automatic int ws_of(input int sel);
        return (sel == 0) ? WS0 : WS1;
    endfunction

    function automatic void model(input int sel, input bit we, input logic [63:0] addr,
                                  input logic [2:0] f3, input logic [63:0] wd,
                                  output bit err, output logic [63:0] rd);
        int size;
        int off;
        int w;
        logic [63:0] word;
        logic [63:0] v;
        logic [63:0] lowmask;
        size = 1 << f3[1:0];
        off  = int'(addr % 8);
        err  = (f3 == 3'b111) || (we && f3 == 3'b110) || ((addr % size) != 0) ||
               (addr >= 64'(DEPTH * 8));
        rd   = 64'd0;
        if (err) return;
        w    = int'(addr / 8);
        word = mdl_mem[sel][w];
        if (we) begin
            for (int i = 0; i < size; i++) word[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
            mdl_mem[sel][w] = word;
        end else begin
            v = word >> (off * 8);
            if (size < 8) begin
                lowmask = (64'd1 << (size * 8)) - 64'd1;
                v = v & lowmask;
                if (!f3[2] && v[size * 8 - 1]) v = v | ~lowmask;
            end
            rd = v;
        end
    endfunction

    // Drives one request and reports what the DUT did; lat counts cycles from accept to ACK.
    task automatic txn(input int sel, input bit we, input logic [63:0] addr, input logic [2:0] f3,
                       input logic [63:0] wd, output int lat, output bit err, output logic [63:0] rd,
                       output bit hs_ok);
        int g;
        g = 0;
        hs_ok = 1'b1;
        err = 1'b0;
        rd = 64'd0;
        @(negedge clk);
        while (ready_s[sel] !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        req_s[sel] = 1'b1; we_s[sel] = we; addr_s[sel] = addr; f3_s[sel] = f3; wd_s[sel] = wd;
        @(negedge clk);
        req_s[sel] = 1'b0; we_s[sel] = $urandom_range(0, 1); addr_s[sel] = {$urandom, $urandom};
        f3_s[sel] = 3'($urandom); wd_s[sel] = {$urandom, $urandom};
        lat = 0;
        forever begin
            lat++;
            if (ready_s[sel] !== 1'b0) hs_ok = 1'b0;
            if (ack_s[sel] === 1'b1) begin
                err = err_s[sel];
                rd  = rdata_s[sel];
                break;
            end
            if (lat > 40) begin
                lat = 999;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (ack_s[sel] !== 1'b0 || err_s[sel] !== 1'b0 || ready_s[sel] !== 1'b1) hs_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = 64'd0; f3_s[s] = 3'd0; wd_s[s] = 64'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ready_s[s] !== 1'b1 || ack_s[s] !== 1'b0 || err_s[s] !== 1'b0 || rdata_s[s] !== 64'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d: ready=%b ack=%b err=%b rdata=%h, want 1 0 0 0",
                         s, ready_s[s], ack_s[s], err_s[s], rdata_s[s]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ready_s[s] !== 1'b1 || ack_s[s] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release dut%0d: ready=%b ack=%b, want 1 0", s, ready_s[s], ack_s[s]);
            end
        end
    endtask

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [2:0]  f3;
        logic [63:0] wd;
        bit          eerr;
        logic [63:0] erd;
        bit          chk_rd;
        string       name;
    } op_t;

    task automatic test_directed();
        op_t tbl[$];
        int lat;
        bit err, hs, merr;
        logic [63:0] rd, mrd;
        tbl.push_back('{1, 64'h10, 3'b011, 64'h1122334455667788, 0, 64'h0, 0, "sd_0x10"});
        tbl.push_back('{0, 64'h10, 3'b011, 64'h0, 0, 64'h1122334455667788, 1, "ld_0x10"});
        tbl.push_back('{1, 64'h13, 3'b000, 64'h80, 0, 64'h0, 0, "sb_0x13"});
        tbl.push_back('{0, 64'h13, 3'b000, 64'h0, 0, 64'hFFFFFFFFFFFFFF80, 1, "lb_0x13"});
        tbl.push_back('{0, 64'h13, 3'b100, 64'h0, 0, 64'h80, 1, "lbu_0x13"});
        tbl.push_back('{0, 64'h10, 3'b011, 64'h0, 0, 64'h1122334480667788, 1, "ld_after_sb"});
        tbl.push_back('{0, 64'h11, 3'b001, 64'h0, 1, 64'h0, 1, "lh_misaligned"});
        tbl.push_back('{1, 64'h12, 3'b010, 64'hDEADBEEF, 1, 64'h0, 0, "sw_misaligned"});
        tbl.push_back('{0, 64'h10, 3'b011, 64'h0, 0, 64'h1122334480667788, 1, "ld_after_bad_sw"});
        tbl.push_back('{1, 64'h800, 3'b011, 64'hCAFE, 1, 64'h0, 0, "sd_out_of_range"});
        tbl.push_back('{0, 64'h800, 3'b011, 64'h0, 1, 64'h0, 1, "ld_out_of_range"});
        tbl.push_back('{0, 64'h10, 3'b111, 64'h0, 1, 64'h0, 1, "load_f3_111"});
        tbl.push_back('{1, 64'h10, 3'b111, 64'h55, 1, 64'h0, 0, "store_f3_111"});
        tbl.push_back('{1, 64'h10, 3'b110, 64'h66, 1, 64'h0, 0, "store_f3_110"});
        tbl.push_back('{0, 64'h10, 3'b011, 64'h0, 0, 64'h1122334480667788, 1, "ld_after_errors"});
        for (int s = 0; s < 2; s++) begin
            foreach (tbl[i]) begin
                model(s, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, merr, mrd);
                txn(s, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, lat, err, rd, hs);
                checks++;
                if (lat != ws_of(s) + 1 || !hs) begin
                    failures++;
                    $display("FAIL %s_timing dut%0d: ack after %0d cycles hs_ok=%b, want %0d and 1",
                             tbl[i].name, s, lat, hs, ws_of(s) + 1);
                end
                checks++;
                if (err !== tbl[i].eerr || (tbl[i].chk_rd && rd !== tbl[i].erd)) begin
                    failures++;
                    $display("FAIL %s dut%0d: err=%b rdata=%h, want err=%b rdata=%h",
                             tbl[i].name, s, err, rd, tbl[i].eerr, tbl[i].erd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int p, acks, ws;
        logic [63:0] exp;
        bit merr;
        for (int s = 0; s < 2; s++) begin
            ws = ws_of(s);
            p = ws + 2;
            acks = 0;
            model(s, 1'b0, 64'h10, 3'b011, 64'd0, merr, exp);
            @(negedge clk);
            req_s[s] = 1'b1; we_s[s] = 1'b0; addr_s[s] = 64'h10; f3_s[s] = 3'b011;
            for (int i = 1; i <= 3 * p; i++) begin
                @(negedge clk);
                if (ack_s[s] === 1'b1) acks++;
                checks++;
                if (ack_s[s] !== ((i % p) == p - 1) || ready_s[s] !== ((i % p) == 0)) begin
                    failures++;
                    $display("FAIL b2b_pattern dut%0d cycle %0d: ack=%b ready=%b, want %b %b",
                             s, i, ack_s[s], ready_s[s], (i % p) == p - 1, (i % p) == 0);
                end
                if ((i % p) == p - 1) begin
                    checks++;
                    if (rdata_s[s] !== exp || err_s[s] !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_rdata dut%0d: rdata=%h err=%b, want %h 0", s, rdata_s[s], err_s[s], exp);
                    end
                end
            end
            req_s[s] = 1'b0;
            checks++;
            if (acks != 3) begin
                failures++;
                $display("FAIL b2b_ack_count dut%0d: %0d acks, want 3", s, acks);
            end
            repeat (p) @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        int lat, noack;
        bit err, hs, merr;
        logic [63:0] rd, exp;
        // dut0 aborted in WAIT, dut1 aborted during its ACK cycle (reset beats the commit edge).
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            req_s[s] = 1'b1; we_s[s] = 1'b1; addr_s[s] = 64'h10; f3_s[s] = 3'b011; wd_s[s] = 64'hA5A5A5A5A5A5A5A5;
            @(negedge clk);
            req_s[s] = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checks++;
            if (ready_s[s] !== 1'b1 || ack_s[s] !== 1'b0 || err_s[s] !== 1'b0) begin
                failures++;
                $display("FAIL abort_ready dut%0d: ready=%b ack=%b err=%b, want 1 0 0", s, ready_s[s], ack_s[s], err_s[s]);
            end
            noack = 1;
            repeat (5) begin
                @(negedge clk);
                if (ack_s[s] !== 1'b0) noack = 0;
            end
            checks++;
            if (noack != 1) begin
                failures++;
                $display("FAIL abort_no_ack dut%0d: ack seen=%0d, want 0", s, 1 - noack);
            end
            model(s, 1'b0, 64'h10, 3'b011, 64'd0, merr, exp);
            txn(s, 1'b0, 64'h10, 3'b011, 64'd0, lat, err, rd, hs);
            checks++;
            if (rd !== exp || err !== 1'b0 || lat != ws_of(s) + 1) begin
                failures++;
                $display("FAIL abort_no_write dut%0d: rdata=%h err=%b lat=%0d, want %h 0 %0d",
                         s, rd, err, lat, exp, ws_of(s) + 1);
            end
        end
    endtask

    task automatic test_random();
        int lat, w;
        bit err, hs, merr, we;
        logic [63:0] rd, mrd, addr, wd;
        logic [2:0] f3;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 8; k++) begin
                wd = {$urandom, $urandom};
                model(s, 1'b1, 64'(k * 8), 3'b011, wd, merr, mrd);
                txn(s, 1'b1, 64'(k * 8), 3'b011, wd, lat, err, rd, hs);
            end
            for (int n = 0; n < 80; n++) begin
                w    = $urandom_range(0, 7);
                addr = 64'(w * 8 + $urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) addr = addr | (64'd1 << $urandom_range(11, 63));
                f3   = 3'($urandom);
                we   = $urandom_range(0, 1);
                wd   = {$urandom, $urandom};
                model(s, we, addr, f3, wd, merr, mrd);
                txn(s, we, addr, f3, wd, lat, err, rd, hs);
                checks++;
                if (lat != ws_of(s) + 1 || !hs || err !== merr || ((!we || merr) && rd !== mrd)) begin
                    failures++;
                    $display("FAIL random dut%0d op%0d we=%b addr=%h f3=%0d: lat=%0d hs=%b err=%b rdata=%h, want lat=%0d err=%b rdata=%h",
                             s, n, we, addr, f3, lat, hs, err, rd, ws_of(s) + 1, merr, mrd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
